stream_accumulator: RTL and testbench

- Downstream consumer of the 4-bit combinational adder stage.
- Takes a stream of WIDTH-bit operands over a valid/ready handshake and sums COUNT consecutive accepted operands, modulo 2^WIDTH.
- Presents each completed sum with a sticky carry-overflow flag on an output valid/ready handshake.
- Sits between the operand source and any result sink that needs batched sums.

---
 rtl/stream_accumulator_if.sv | 51 +++++
 rtl/stream_accumulator.sv | 116 +++++++++++
 tb/tb_stream_accumulator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_accumulator_if.sv
// ---------------------------------------------------------------------------
// stream_accumulator_if
//
// Operand and result handshake bundle for stream_accumulator.
//
// Signals:
//   in_data   [WIDTH]  operand from the source
//   in_valid           operand valid
//   in_ready           accumulator can accept an operand
//   out_data  [WIDTH]  completed batch sum (mod 2^WIDTH)
//   out_ovf            carry-out occurred somewhere in the batch
//   out_valid          result valid
//   out_ready          sink accepts the result
//
// Modports:
//   master - the environment side (drives operands, consumes results)
//   slave  - the accumulator side
// ---------------------------------------------------------------------------
interface stream_accumulator_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_ovf,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_ovf,
    output out_valid
  );

endinterface

// File: rtl/stream_accumulator.sv
// ---------------------------------------------------------------------------
// stream_accumulator
//
// Sums COUNT consecutive accepted WIDTH-bit operands modulo 2^WIDTH and
// presents each batch sum, together with a sticky carry-overflow flag, on an
// output valid/ready handshake.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous batch abort (drops partial sum and pending result)
//   bus  - stream_accumulator_if.slave: operand in / result out handshakes
//
// Two states: ACC collects operands (in_ready=1), OUT holds the result until
// the sink takes it (out_valid=1). All outputs are registered except
// in_ready, which is a pure decode of the state register.
// ---------------------------------------------------------------------------
module stream_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  stream_accumulator_if.slave   bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;
  logic             out_valid_q;

  // Running sum one bit wider than the accumulator; the MSB is the carry.
  logic [WIDTH:0]   add_d;
  logic             in_ready_s;
  logic             accept_s;

  // Widened add of the current accumulator and the incoming operand.
  always_comb begin
    add_d = {1'b0, acc_q} + {1'b0, bus.in_data};
  end

  assign in_ready_s = (state_q == ST_ACC);
  assign accept_s   = bus.in_valid & in_ready_s;

  // Batch FSM: accumulate, publish result, wait for the sink.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      // Abort wins over any handshake in the same cycle; the last published
      // result value stays on out_data/out_ovf.
      state_q     <= ST_ACC;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept_s) begin
            if (cnt_q == CNT_LAST) begin
              // Last operand of the batch: publish straight from the adder
              // so the result appears one cycle after this accept.
              out_data_q  <= add_d[WIDTH-1:0];
              out_ovf_q   <= ovf_q | add_d[WIDTH];
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              ovf_q       <= 1'b0;
              cnt_q       <= '0;
              state_q     <= ST_OUT;
            end else begin
              acc_q <= add_d[WIDTH-1:0];
              ovf_q <= ovf_q | add_d[WIDTH];
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_stream_accumulator
//
// Self-checking bench for stream_accumulator (WIDTH=4, COUNT=4). A table of
// per-cycle vectors with hand-computed expectations covers the basic,
// overflow, backpressure and bubble cases; hand-written sequences cover clr
// and asynchronous reset; a random phase runs against a queue-based model
// that sums each batch with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_stream_accumulator;

  localparam int WIDTH = 4;
  localparam int COUNT = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  stream_accumulator_if #(.WIDTH(WIDTH)) bus ();

  stream_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: operands of the open batch, plus the published result.
  int batch_q[$];
  bit m_pending;
  int m_data;
  bit m_ovf;

  typedef struct {
    bit         v;
    logic [3:0] d;
    bit         ordy;
    bit         valid;
    logic [3:0] data;
    bit         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    batch_q.delete();
    m_pending = 1'b0;
    m_data    = 0;
    m_ovf     = 1'b0;
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_step(input bit v, input int d, input bit ordy, input bit c);
    if (c) begin
      batch_q.delete();
      m_pending = 1'b0;
    end else if (!m_pending) begin
      if (v) begin
        batch_q.push_back(d);
        if (batch_q.size() == COUNT) begin
          int total;
          total = 0;
          foreach (batch_q[i]) total += batch_q[i];
          // Each carry-out removes 2^WIDTH, so any carry <=> total >= 2^WIDTH.
          m_data    = total % (1 << WIDTH);
          m_ovf     = (total >= (1 << WIDTH));
          m_pending = 1'b1;
          batch_q.delete();
        end
      end
    end else if (ordy) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, !m_pending});
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_pending});
    chk({tag, ".out_data"},  {28'd0, bus.out_data},  m_data);
    chk({tag, ".out_ovf"},   {31'd0, bus.out_ovf},   {31'd0, m_ovf});
  endtask

  // Called at a falling edge: drive, clock, then check at the next falling edge.
  task automatic cycle(input bit v, input logic [3:0] d, input bit ordy, input bit c,
                       input string tag);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr           = c;
    @(posedge clk);
    model_step(v, int'(d), ordy, c);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic add_vec(input bit v, input logic [3:0] d, input bit ordy,
                         input bit valid, input logic [3:0] data, input bit ovf);
    vec_t r;
    r.v = v; r.d = d; r.ordy = ordy; r.valid = valid; r.data = data; r.ovf = ovf;
    vecs.push_back(r);
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    // Basic sum 1+2+3+4
    add_vec(1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
    add_vec(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0);
    add_vec(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    add_vec(1'b1, 4'd4, 1'b1, 1'b1, 4'd10, 1'b0);
    add_vec(1'b0, 4'd0, 1'b1, 1'b0, 4'd10, 1'b0);
    // Overflow 8,8,1,0 then 1,1,1,1 clears ovf
    add_vec(1'b1, 4'd8, 1'b1, 1'b0, 4'd10, 1'b0);
    add_vec(1'b1, 4'd8, 1'b1, 1'b0, 4'd10, 1'b0);
    add_vec(1'b1, 4'd1, 1'b1, 1'b0, 4'd10, 1'b0);
    add_vec(1'b1, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1);
    add_vec(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) add_vec(1'b1, 4'd1, 1'b1, 1'b0, 4'd1, 1'b1);
    add_vec(1'b1, 4'd1, 1'b1, 1'b1, 4'd4, 1'b0);
    add_vec(1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0);
    // Backpressure 15,1,0,0 held for 3 cycles with in_valid high
    add_vec(1'b1, 4'd15, 1'b0, 1'b0, 4'd4, 1'b0);
    add_vec(1'b1, 4'd1,  1'b0, 1'b0, 4'd4, 1'b0);
    add_vec(1'b1, 4'd0,  1'b0, 1'b0, 4'd4, 1'b0);
    add_vec(1'b1, 4'd0,  1'b0, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) add_vec(1'b1, 4'd7, 1'b0, 1'b1, 4'd0, 1'b1);
    add_vec(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) add_vec(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b1);
    add_vec(1'b1, 4'd2, 1'b1, 1'b1, 4'd8, 1'b0);
    add_vec(1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0);
    // Bubbles 2,_,_,3,_,5,7
    add_vec(1'b1, 4'd2, 1'b1, 1'b0, 4'd8, 1'b0);
    add_vec(1'b0, 4'd9, 1'b1, 1'b0, 4'd8, 1'b0);
    add_vec(1'b0, 4'd9, 1'b1, 1'b0, 4'd8, 1'b0);
    add_vec(1'b1, 4'd3, 1'b1, 1'b0, 4'd8, 1'b0);
    add_vec(1'b0, 4'd9, 1'b1, 1'b0, 4'd8, 1'b0);
    add_vec(1'b1, 4'd5, 1'b1, 1'b0, 4'd8, 1'b0);
    add_vec(1'b1, 4'd7, 1'b1, 1'b1, 4'd1, 1'b1);
    add_vec(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1);

    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].ordy, 1'b0, "tbl_model");
      chk("tbl.out_valid", {31'd0, bus.out_valid}, {31'd0, vecs[i].valid});
      chk("tbl.in_ready",  {31'd0, bus.in_ready},  {31'd0, !vecs[i].valid});
      chk("tbl.out_data",  {28'd0, bus.out_data},  {28'd0, vecs[i].data});
      chk("tbl.out_ovf",   {31'd0, bus.out_ovf},   {31'd0, vecs[i].ovf});
    end

    // clr after two accepts, with a simultaneous operand that must be dropped
    cycle(1'b1, 4'd5, 1'b1, 1'b0, "clr");
    cycle(1'b1, 4'd5, 1'b1, 1'b0, "clr");
    cycle(1'b1, 4'd6, 1'b1, 1'b1, "clr");
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd1, 1'b1, 1'b0, "clr");
    chk("clr.out_data",  {28'd0, bus.out_data}, 32'd4);
    chk("clr.out_ovf",   {31'd0, bus.out_ovf},  32'd0);
    chk("clr.out_valid", {31'd0, bus.out_valid}, 32'd1);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, "clr");

    // clr while a result is pending: valid drops, data holds
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd3, 1'b0, 1'b0, "clr_out");
    cycle(1'b0, 4'd0, 1'b1, 1'b1, "clr_out");
    chk("clr_out.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("clr_out.out_data",  {28'd0, bus.out_data},  32'd12);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd4, 1'b1, 1'b0, "clr_out");
    cycle(1'b0, 4'd0, 1'b1, 1'b0, "clr_out");

    // Asynchronous reset while a result is pending
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd9, 1'b0, 1'b0, "rst_out");
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out.out_data",  {28'd0, bus.out_data},  32'd0);
    chk("rst_out.out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Asynchronous reset mid-batch loses the partial sum
    cycle(1'b1, 4'd7, 1'b1, 1'b0, "rst_mid");
    cycle(1'b1, 4'd7, 1'b1, 1'b0, "rst_mid");
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0, "rst_mid");
    chk("rst_mid.out_data",  {28'd0, bus.out_data},  32'd10);
    chk("rst_mid.out_valid", {31'd0, bus.out_valid}, 32'd1);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, "rst_mid");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
